// File: rtl/program_loader.sv
// Boot-time program loader for the Bananachine.
// It receives a byte stream: a 16-bit big-endian word count N, then N
// big-endian words. Each word is written to unified memory port B, and
// the CPU is held in reset until the whole image has been written.
module program_loader #(
  parameter int          WIDTH     = 16,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          MAX_WORDS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] words_loaded
);

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [7:0]  count_hi;
  logic [15:0] count;
  logic [7:0]  data_hi;
  logic        transfer;
  logic [15:0] header_count;
  logic [31:0] next_index;

  // State register; reset always returns to IDLE, whatever the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. byte_ready is registered, so it already reflects the current state.
  always_comb begin
    next_state   = state;
    transfer     = byte_valid & byte_ready;
    header_count = {count_hi, byte_in};
    next_index   = 32'(words_loaded) + 32'd1;
    case (state)
      IDLE: begin
        if (start) next_state = CNT_HI;
      end
      CNT_HI: begin
        if (transfer) next_state = CNT_LO;
      end
      CNT_LO: begin
        if (transfer) begin
          if (header_count == 16'd0)
            next_state = DONE;
          else if ({16'd0, header_count} > 32'(MAX_WORDS))
            next_state = ERROR;
          else
            next_state = DATA_HI;
        end
      end
      DATA_HI: begin
        if (transfer) next_state = DATA_LO;
      end
      DATA_LO: begin
        if (transfer) next_state = WRITE;
      end
      WRITE: begin
        if (next_index == {16'd0, count})
          next_state = DONE;
        else
          next_state = DATA_HI;
      end
      DONE:    next_state = DONE;
      ERROR:   next_state = ERROR;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs and datapath. Outputs are decoded from the next state so each one lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      count_hi     <= '0;
      count        <= '0;
      data_hi      <= '0;
    end else begin
      byte_ready <= (next_state == CNT_HI) || (next_state == CNT_LO) ||
                    (next_state == DATA_HI) || (next_state == DATA_LO);
      mem_we     <= (next_state == WRITE);
      cpu_hold   <= (next_state != DONE);
      done       <= (next_state == DONE);
      error      <= (next_state == ERROR);

      if (state == CNT_HI && transfer) count_hi <= byte_in;
      if (state == CNT_LO && transfer) count <= header_count;
      if (state == DATA_HI && transfer) data_hi <= byte_in;

      if (next_state == WRITE) begin
        mem_addr <= WIDTH'(BASE_ADDR) + words_loaded;
        mem_data <= WIDTH'({data_hi, byte_in});
      end

      if (state == WRITE) words_loaded <= words_loaded + 1'b1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader.
// It compares memory writes and status flags against values computed
// from the stream format: word i lands at BASE+i (mod 2^16).
module tb_program_loader;

  localparam int WIDTH = 16;
  localparam int BASE  = 'hFFFE;
  localparam int MAXW  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int timeouts = 0;

  logic [15:0] img [0:7];
  logic [31:0] wr_q [$];
  int long_pulses = 0;
  int ready_bad = 0;
  int run_len = 0;

  program_loader #(.WIDTH(WIDTH), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .cpu_hold(cpu_hold),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every memory write and flag write pulses longer than one cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_q.push_back({mem_addr, mem_data});
      run_len++;
      if (run_len == 2) long_pulses++;
      if (byte_ready) ready_bad++;
    end else begin
      run_len = 0;
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_in = b;
    waited = 0;
    while (!byte_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_ready) timeouts++;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input string name, input int n, input int gap);
    int base, lp0, rb0, to0, exp_n, got_n;
    logic [15:0] nn;
    logic [31:0] exp_w;
    nn = 16'(n);
    base = wr_q.size(); lp0 = long_pulses; rb0 = ready_bad; to0 = timeouts;
    pulse_start();
    send_byte(nn[15:8], gap);
    send_byte(nn[7:0], gap);
    if (n == 0) begin
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL %s zero_done actual %0b required 1", name, done); end
      checks++; if (cpu_hold !== 1'b0) begin errors++; $display("[TB] FAIL %s zero_hold actual %0b required 0", name, cpu_hold); end
    end else if (n > MAXW) begin
      checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL %s long_error actual %0b required 1", name, error); end
      checks++; if (byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL %s long_ready actual %0b required 0", name, byte_ready); end
    end else begin
      for (int i = 0; i < n; i++) begin
        send_byte(img[i][15:8], gap);
        send_byte(img[i][7:0], gap);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL %s we_latency[%0d] actual %0b required 1", name, i, mem_we); end
        checks++; if (mem_addr !== 16'(BASE + i)) begin errors++; $display("[TB] FAIL %s addr[%0d] actual %h required %h", name, i, mem_addr, 16'(BASE + i)); end
        checks++; if (words_loaded !== 16'(i)) begin errors++; $display("[TB] FAIL %s count_in_write[%0d] actual %0d required %0d", name, i, words_loaded, i); end
      end
    end
    repeat (3) @(negedge clk);
    exp_n = (n > MAXW) ? 0 : n;
    got_n = wr_q.size() - base;
    checks++; if (got_n != exp_n) begin errors++; $display("[TB] FAIL %s write_count actual %0d required %0d", name, got_n, exp_n); end
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      exp_w = {16'(BASE + i), img[i]};
      checks++; if (wr_q[base + i] !== exp_w) begin errors++; $display("[TB] FAIL %s write[%0d] actual %h required %h", name, i, wr_q[base + i], exp_w); end
    end
    checks++; if (done !== (n <= MAXW)) begin errors++; $display("[TB] FAIL %s done actual %0b required %0b", name, done, n <= MAXW); end
    checks++; if (error !== (n > MAXW)) begin errors++; $display("[TB] FAIL %s error actual %0b required %0b", name, error, n > MAXW); end
    checks++; if (cpu_hold !== (n > MAXW)) begin errors++; $display("[TB] FAIL %s cpu_hold actual %0b required %0b", name, cpu_hold, n > MAXW); end
    checks++; if (words_loaded !== 16'(exp_n)) begin errors++; $display("[TB] FAIL %s words_loaded actual %0d required %0d", name, words_loaded, exp_n); end
    checks++; if (byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL %s final_ready actual %0b required 0", name, byte_ready); end
    checks++; if (long_pulses != lp0) begin errors++; $display("[TB] FAIL %s we_pulse_width long_pulses %0d required 0", name, long_pulses - lp0); end
    checks++; if (ready_bad != rb0) begin errors++; $display("[TB] FAIL %s ready_in_write count %0d required 0", name, ready_bad - rb0); end
    checks++; if (timeouts != to0) begin errors++; $display("[TB] FAIL %s handshake_timeouts actual %0d required 0", name, timeouts - to0); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({byte_ready, mem_we, cpu_hold, done, error} !== 5'b00100) begin errors++; $display("[TB] FAIL reset_flags actual %b required 00100", {byte_ready, mem_we, cpu_hold, done, error}); end
    checks++; if ({mem_addr, mem_data, words_loaded} !== 48'd0) begin errors++; $display("[TB] FAIL reset_regs actual %h required 0", {mem_addr, mem_data, words_loaded}); end
  endtask

  task automatic test_ignored_idle();
    do_reset();
    byte_valid = 1'b1; byte_in = 8'h55;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (byte_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_ready[%0d] actual %0b required 0", i, byte_ready); end
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_basic();
    img[0] = 16'h1234; img[1] = 16'hABCD;
    run_load("basic", 2, 0);
  endtask

  task automatic test_start_in_done();
    int base;
    base = wr_q.size();
    pulse_start();
    repeat (4) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL done_start_done actual %0b required 1", done); end
    checks++; if (wr_q.size() != base) begin errors++; $display("[TB] FAIL done_start_writes actual %0d required 0", wr_q.size() - base); end
  endtask

  task automatic test_backpressure();
    do_reset();
    img[0] = 16'h1234; img[1] = 16'hABCD;
    run_load("backpressure", 2, 3);
  endtask

  task automatic test_zero_length();
    do_reset();
    run_load("zero", 0, 0);
  endtask

  task automatic test_too_long();
    int base;
    do_reset();
    run_load("too_long", 5, 0);
    base = wr_q.size();
    byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    pulse_start();
    repeat (3) @(negedge clk);
    checks++; if ({error, cpu_hold, byte_ready, done} !== 4'b1100) begin errors++; $display("[TB] FAIL too_long_sticky actual %b required 1100", {error, cpu_hold, byte_ready, done}); end
    checks++; if (wr_q.size() != base) begin errors++; $display("[TB] FAIL too_long_writes actual %0d required 0", wr_q.size() - base); end
  endtask

  task automatic test_reset_mid_load();
    int base;
    do_reset();
    for (int i = 0; i < 3; i++) img[i] = 16'($urandom);
    base = wr_q.size();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(img[0][15:8], 0);
    send_byte(img[0][7:0], 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({mem_we, cpu_hold, byte_ready, done} !== 4'b0100) begin errors++; $display("[TB] FAIL mid_reset_flags actual %b required 0100", {mem_we, cpu_hold, byte_ready, done}); end
    checks++; if (words_loaded !== 16'd0) begin errors++; $display("[TB] FAIL mid_reset_count actual %0d required 0", words_loaded); end
    checks++; if (wr_q.size() - base != 1) begin errors++; $display("[TB] FAIL mid_reset_writes actual %0d required 1", wr_q.size() - base); end
    for (int i = 0; i < 3; i++) img[i] = 16'($urandom);
    run_load("mid_reload", 3, 0);
  endtask

  task automatic test_random();
    int n, gap;
    for (int k = 0; k < 10; k++) begin
      do_reset();
      n = $urandom_range(0, 6);
      gap = $urandom_range(0, 2);
      for (int i = 0; i < 8; i++) img[i] = 16'($urandom);
      run_load($sformatf("random%0d", k), n, gap);
    end
  endtask

  initial begin
    test_reset();
    test_ignored_idle();
    test_basic();
    test_start_in_done();
    test_backpressure();
    test_zero_length();
    test_too_long();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
